// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (fixed priority, load/store wins ties).
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;

    localparam int NPORT   = 2;
    localparam int PORT_IF = 0;
    localparam int PORT_LS = 1;
    localparam int CNT_W   = 4;
endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way arbiter: round-robin on the last-grant pointer, or fixed priority
// (port 1 wins) when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [NPORT-1:0] i_req,
    input  logic             i_last,
    input  logic             i_en,
    output logic [NPORT-1:0] o_gnt,
    output logic             o_win
);
    always_comb begin
        o_gnt = '0;
        o_win = 1'b0;
        if (i_en && (|i_req)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            o_win = i_req[PORT_LS];
`else
            // On a tie the port that was not granted last goes next.
            if (&i_req) o_win = ~i_last;
            else        o_win = i_req[PORT_LS];
`endif
            o_gnt[o_win] = 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for one shared fixed-latency SRAM, one transaction in flight.
// Build macro MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [NPORT-1:0]     i_req,
    input  logic [NPORT-1:0]     i_we,
    input  logic [2*XLEN-1:0]    i_addr,
    input  logic [2*XLEN-1:0]    i_wdata,
    output logic [NPORT-1:0]     o_gnt,
    output logic [NPORT-1:0]     o_rsp_valid,
    output logic [NPORT-1:0]     o_rsp_err,
    output logic [XLEN-1:0]      o_rdata,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [XLEN-1:0]      o_mem_addr,
    output logic [XLEN-1:0]      o_mem_wdata,
    input  logic [XLEN-1:0]      i_mem_rdata,
    output state_t               o_dbg_state
);
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_owner, r_we;
    logic               w_last, w_win;
    logic [NPORT-1:0]   w_gnt;
    logic [XLEN-1:0]    w_addr_win, w_wdata_win;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_last = 1'b1;
`else
    logic r_last;
    assign w_last = r_last;
`endif

    rr_arb2 u_arb (
        .i_req  (i_req),
        .i_last (w_last),
        .i_en   (r_state == IDLE),
        .o_gnt  (w_gnt),
        .o_win  (w_win)
    );

    assign w_addr_win  = i_addr[w_win*XLEN +: XLEN];
    assign w_wdata_win = i_wdata[w_win*XLEN +: XLEN];
    assign o_dbg_state = r_state;

    // Handshake: a requester holds req/we/addr/wdata until it sees its
    // one-cycle gnt; the matching rsp_valid pulse follows later.
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        o_gnt       = '0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = {w_addr_win[XLEN-1:2], 2'b00};
        o_mem_wdata = w_wdata_win;
        o_rsp_valid = '0;
        o_rsp_err   = '0;
        o_rdata     = '0;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    o_gnt = w_gnt;
                    if (|w_addr_win[1:0]) begin
                        w_next = ERR;
                    end else begin
                        o_mem_req  = 1'b1;
                        o_mem_we   = i_we[w_win];
                        w_next     = BUSY;
                        w_cnt_next = CNT_W'(LAT - 1);
                    end
                end
            end
            BUSY: begin
                // Count 0 is the cycle the SRAM presents read data.
                if (r_cnt == '0) begin
                    o_rsp_valid[r_owner] = 1'b1;
                    o_rdata              = r_we ? '0 : i_mem_rdata;
                    w_next               = IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ERR: begin
                o_rsp_valid[r_owner] = 1'b1;
                o_rsp_err[r_owner]   = 1'b1;
                w_next               = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (|o_gnt) begin
                r_owner <= w_win;
                r_we    <= i_we[w_win];
            end
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!i_reset)         r_last <= 1'b1;
        else if (|o_gnt)      r_last <= w_win;
    end
`endif
endmodule
